// File: rtl/ofdm_subcarrier_map.sv
// Ping-pong buffers 48 mapper symbols and emits 64-carrier frames (data, 4 pilots, 12 nulls); valid_o rises 2 cycles after the 48th write.
// in_ready drops while the write bank is full; outputs hold while !ready_i. Define PILOT_POLARITY_EN for LFSR-driven pilot polarity.
module ofdm_subcarrier_map #(
  parameter int W         = 11,
  parameter int PILOT_AMP = 1023
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         valid_i,
  input  logic [W-1:0] xr_i,
  input  logic [W-1:0] xi_i,
  output logic         in_ready,
  output logic [W-1:0] yr_o,
  output logic [W-1:0] yi_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         sof_o,
  output logic         eof_o,
  output logic [15:0]  frames_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [W-1:0] PILOT_POS = W'(PILOT_AMP);

  logic [2*W-1:0] mem_q [0:95];
  state_t         state_q, state_d;
  logic [1:0]     bank_full_q, bank_full_d;
  logic           wb_q, wb_d, rb_q, rb_d;
  logic [5:0]     widx_q, widx_d, ridx_q, ridx_d;
  logic           valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic [W-1:0]   yr_q, yr_d, yi_q, yi_d;
  logic [15:0]    frames_q, frames_d;
  logic           wr_en, frame_done, load;
  logic [6:0]     wr_addr, rd_addr;
  logic [5:0]     load_k, didx;
  logic           is_null, is_pilot;
  logic [W-1:0]   pilot_val, smp_r, smp_i;

  assign in_ready = !RST && !bank_full_q[wb_q];
  assign wr_en    = valid_i && in_ready;
  assign wr_addr  = (wb_q ? 7'd48 : 7'd0) + {1'b0, widx_q};

`ifdef PILOT_POLARITY_EN
  localparam logic [W-1:0] PILOT_NEG = W'(-PILOT_AMP);
  logic [6:0] lfsr_q, lfsr_d;

  // x^7+x^4+1; the bit leaving the top sets this frame's pilot sign
  always_comb begin
    lfsr_d = lfsr_q;
    if (frame_done) lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[3]};
  end

  always_ff @(posedge CLK) begin
    if (RST) lfsr_q <= 7'h7F;
    else     lfsr_q <= lfsr_d;
  end

  assign pilot_val = lfsr_q[6] ? PILOT_NEG : PILOT_POS;
`else
  assign pilot_val = PILOT_POS;
`endif

  always_comb begin
    widx_d      = widx_q;
    wb_d        = wb_q;
    bank_full_d = bank_full_q;
    if (wr_en) begin
      if (widx_q == 6'd47) begin
        widx_d            = 6'd0;
        wb_d              = ~wb_q;
        bank_full_d[wb_q] = 1'b1;
      end else begin
        widx_d = widx_q + 6'd1;
      end
    end
    if (frame_done) bank_full_d[rb_q] = 1'b0;
  end

  // Carrier to load next: the current one when the output register is empty, else the following one
  always_comb begin
    load_k   = valid_q ? ridx_q + 6'd1 : ridx_q;
    is_pilot = (load_k == 6'd7) || (load_k == 6'd21) || (load_k == 6'd43) || (load_k == 6'd57);
    is_null  = (load_k == 6'd0) || ((load_k >= 6'd27) && (load_k <= 6'd37));
    if (load_k < 6'd7)       didx = load_k - 6'd1;
    else if (load_k < 6'd21) didx = load_k - 6'd2;
    else if (load_k < 6'd27) didx = load_k - 6'd3;
    else if (load_k < 6'd43) didx = load_k - 6'd14;
    else if (load_k < 6'd57) didx = load_k - 6'd15;
    else                     didx = load_k - 6'd16;
    rd_addr = (rb_q ? 7'd48 : 7'd0) + {1'b0, didx};
    smp_r   = mem_q[rd_addr][2*W-1:W];
    smp_i   = mem_q[rd_addr][W-1:0];
    if (is_null) begin
      smp_r = '0;
      smp_i = '0;
    end else if (is_pilot) begin
      smp_r = pilot_val;
      smp_i = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    ridx_d     = ridx_q;
    rb_d       = rb_q;
    valid_d    = valid_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    yr_d       = yr_q;
    yi_d       = yi_q;
    frames_d   = frames_q;
    frame_done = 1'b0;
    load       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bank_full_q[rb_q]) begin
          state_d = S_RUN;
          ridx_d  = 6'd0;
        end
      end
      S_RUN: begin
        if (!valid_q) begin
          load = 1'b1;
        end else if (ready_i) begin
          if (ridx_q == 6'd63) begin
            frame_done = 1'b1;
            valid_d    = 1'b0;
            sof_d      = 1'b0;
            eof_d      = 1'b0;
            yr_d       = '0;
            yi_d       = '0;
            rb_d       = ~rb_q;
            ridx_d     = 6'd0;
            frames_d   = frames_q + 16'd1;
            // Skipping IDLE when the other bank is ready keeps the inter-frame gap to one cycle
            state_d    = bank_full_q[~rb_q] ? S_RUN : S_IDLE;
          end else begin
            ridx_d = ridx_q + 6'd1;
            load   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      valid_d = 1'b1;
      sof_d   = (load_k == 6'd0);
      eof_d   = (load_k == 6'd63);
      yr_d    = smp_r;
      yi_d    = smp_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      bank_full_q <= 2'b00;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      widx_q      <= 6'd0;
      ridx_q      <= 6'd0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      yr_q        <= '0;
      yi_q        <= '0;
      frames_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      bank_full_q <= bank_full_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      widx_q      <= widx_d;
      ridx_q      <= ridx_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      yr_q        <= yr_d;
      yi_q        <= yi_d;
      frames_q    <= frames_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_addr] <= {xr_i, xi_i};
  end

  assign valid_o  = valid_q;
  assign sof_o    = sof_q;
  assign eof_o    = eof_q;
  assign yr_o     = yr_q;
  assign yi_o     = yi_q;
  assign frames_o = frames_q;

endmodule

// File: tb/tb_ofdm_subcarrier_map.sv
// Directed bench for ofdm_subcarrier_map: single frame, stall, both banks full, mid-frame reset, frame counter wrap.
module tb_ofdm_subcarrier_map;
  localparam int W = 11;

  logic         CLK = 1'b0;
  logic         RST, valid_i, ready_i;
  logic [W-1:0] xr_i, xi_i;
  logic         in_ready, valid_o, sof_o, eof_o;
  logic [W-1:0] yr_o, yi_o;
  logic [15:0]  frames_o;

  ofdm_subcarrier_map #(.W(W), .PILOT_AMP(1023)) dut (
    .CLK(CLK), .RST(RST), .valid_i(valid_i), .xr_i(xr_i), .xi_i(xi_i),
    .in_ready(in_ready), .yr_o(yr_o), .yi_o(yi_o), .valid_o(valid_o),
    .ready_i(ready_i), .sof_o(sof_o), .eof_o(eof_o), .frames_o(frames_o)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int          acc_r[$], acc_i[$], acc_edge_q[$];
  int          frm_r[48], frm_i[48];
  int          mon_k = 0, frames_done = 0;
  logic [15:0] exp_frames = 16'd0;
  logic [6:0]  lfsr_m = 7'h7F;
  int          idle_run = 0, last_gap = -1, rise_edge = -1, eof_edge = -1;
  logic        vld_prev = 1'b0;
  int          m_er, m_ei;

  function automatic bit is_data(input int k);
    return !(k == 0 || (k >= 27 && k <= 37) || k == 7 || k == 21 || k == 43 || k == 57);
  endfunction

  task automatic exp_at(input int k, output int er, output int ei);
    int d;
    er = 0;
    ei = 0;
    if (k == 7 || k == 21 || k == 43 || k == 57) begin
`ifdef PILOT_POLARITY_EN
      er = lfsr_m[6] ? -1023 : 1023;
`else
      er = 1023;
`endif
    end else if (is_data(k)) begin
      d = 0;
      for (int j = 0; j < k; j++) if (is_data(j)) d++;
      er = frm_r[d];
      ei = frm_i[d];
    end
  endtask

  // Output monitor: checks every handshaked sample against the model
  always @(negedge CLK) begin
    #1;
    if (RST) begin
      vld_prev = 1'b0;
      idle_run = 0;
    end else begin
      if (valid_o && !vld_prev) begin
        rise_edge = cyc;
        last_gap  = idle_run;
      end
      idle_run = valid_o ? 0 : idle_run + 1;
      vld_prev = valid_o;
      if (valid_o && ready_i) begin
        if (mon_k == 0) begin
          check("frame_syms_avail", int'(acc_r.size() >= 48), 1);
          for (int j = 0; j < 48; j++) begin
            if (acc_r.size() > 0) begin
              frm_r[j] = acc_r.pop_front();
              frm_i[j] = acc_i.pop_front();
            end else begin
              frm_r[j] = 0;
              frm_i[j] = 0;
            end
          end
        end
        exp_at(mon_k, m_er, m_ei);
        check($sformatf("yr_k%0d", mon_k), int'($signed(yr_o)), m_er);
        check($sformatf("yi_k%0d", mon_k), int'($signed(yi_o)), m_ei);
        check($sformatf("sof_k%0d", mon_k), int'(sof_o), int'(mon_k == 0));
        check($sformatf("eof_k%0d", mon_k), int'(eof_o), int'(mon_k == 63));
        if (mon_k == 63) begin
          check("frames_pre_eof", int'(frames_o), int'(exp_frames));
          eof_edge   = cyc + 1;
          exp_frames = exp_frames + 16'd1;
          frames_done++;
          lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[3]};
          mon_k  = 0;
        end else begin
          mon_k++;
        end
      end
    end
  end

  task automatic send(input int r, input int i);
    bit acc;
    int rr, ii;
    rr = r;
    ii = i;
    acc = 1'b0;
    valid_i = 1'b1;
    xr_i = rr[W-1:0];
    xi_i = ii[W-1:0];
    for (int t = 0; t < 600 && !acc; t++) begin
      acc = in_ready;
      @(negedge CLK);
    end
    if (acc) begin
      acc_r.push_back(r);
      acc_i.push_back(i);
      acc_edge_q.push_back(cyc);
    end
    check("send_accept", int'(acc), 1);
  endtask

  task automatic wait_frames(input int target);
    for (int t = 0; t < 3000 && frames_done < target; t++) @(negedge CLK);
    check("frames_done", frames_done, target);
    check("frames_o", int'(frames_o), int'(exp_frames));
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    valid_i = 1'b0;
    repeat (2) @(negedge CLK);
    check({tag, "_valid_o"}, int'(valid_o), 0);
    check({tag, "_sof_o"}, int'(sof_o), 0);
    check({tag, "_eof_o"}, int'(eof_o), 0);
    check({tag, "_yr_o"}, int'(yr_o), 0);
    check({tag, "_yi_o"}, int'(yi_o), 0);
    check({tag, "_frames_o"}, int'(frames_o), 0);
    acc_r.delete();
    acc_i.delete();
    acc_edge_q.delete();
    mon_k = 0;
    exp_frames = 16'd0;
    lfsr_m = 7'h7F;
    RST = 1'b0;
    @(negedge CLK);
    check({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, done0, eof1, snap_r, snap_i, hold_ok;
    bit feeder_done;
    RST = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    xr_i = '0;
    xi_i = '0;
    feeder_done = 1'b0;
    @(negedge CLK);
    do_reset("rst");

    // Single frame: xr=d, xi=-d
    for (int d = 1; d <= 48; d++) send(d, -d);
    valid_i = 1'b0;
    wait_frames(1);
    check("latency", rise_edge - acc_edge_q[47], 2);

    // Stall at carrier 5
    for (int d = 0; d < 48; d++) send(d * 20 - 480, 300 - d * 13);
    valid_i = 1'b0;
    for (int t = 0; t < 200 && !(valid_o && mon_k == 5); t++) @(negedge CLK);
    check("bp_reach_k5", mon_k, 5);
    ready_i = 1'b0;
    snap_r = int'(yr_o);
    snap_i = int'(yi_o);
    hold_ok = 1;
    repeat (10) begin
      @(negedge CLK);
      if (!valid_o || int'(yr_o) != snap_r || int'(yi_o) != snap_i || sof_o || eof_o) hold_ok = 0;
    end
    check("bp_hold", hold_ok, 1);
    check("bp_no_handshake", mon_k, 5);
    ready_i = 1'b1;
    wait_frames(2);

    // Both banks full, then drain three frames
    ready_i = 1'b0;
    base = acc_edge_q.size();
    done0 = frames_done;
    fork
      begin
        for (int i = 0; i < 144; i++) send(i * 7 - 500, 300 - i * 5);
        valid_i = 1'b0;
        feeder_done = 1'b1;
      end
    join_none
    for (int t = 0; t < 400 && acc_edge_q.size() - base < 96; t++) @(negedge CLK);
    repeat (5) @(negedge CLK);
    check("full_in_ready", int'(in_ready), 0);
    check("full_acc_cnt", acc_edge_q.size() - base, 96);
    ready_i = 1'b1;
    for (int t = 0; t < 400 && frames_done < done0 + 1; t++) @(negedge CLK);
    eof1 = eof_edge;
    wait_frames(done0 + 3);
    check("feeder_done", int'(feeder_done), 1);
    if (acc_edge_q.size() > base + 96) check("restart_lat", acc_edge_q[base + 96] - eof1, 1);
    else check("restart_seen", acc_edge_q.size() - base, 144);
    check("frame_gap", last_gap, 1);

    // Reset at carrier 30 with 20 symbols in the other bank
    ready_i = 1'b0;
    for (int i = 0; i < 68; i++) send(5 * i + 1, -3 * i - 7);
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int t = 0; t < 200 && !(valid_o && mon_k == 30); t++) @(negedge CLK);
    check("rst_reach_k30", mon_k, 30);
    done0 = frames_done;
    do_reset("rst_mid");
    for (int i = 0; i < 48; i++) send(-100 - i, 50 + i);
    valid_i = 1'b0;
    wait_frames(done0 + 1);

    // Frame counter wrap
    force dut.frames_q = 16'hFFFF;
    repeat (2) @(negedge CLK);
    release dut.frames_q;
    exp_frames = 16'hFFFF;
    @(negedge CLK);
    check("wrap_preload", int'(frames_o), 65535);
    done0 = frames_done;
    for (int i = 0; i < 48; i++) send(i, i);
    valid_i = 1'b0;
    wait_frames(done0 + 1);
    check("wrap_zero", int'(frames_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ofdm_subcarrier_map.md
Name: ofdm_subcarrier_map

Overview:
- Downstream of the 16-QAM IQ mapper and upstream of the 64-point IFFT.
- Collects 48 data symbols per OFDM frame into a ping-pong buffer.
- Emits a 64-sample frame in carrier-index order 0..63, with data symbols, 4 pilots and 12 null carriers (DC plus guard) placed per a fixed map.
- Input side back-pressures the mapper through in_ready; output side follows a valid/ready handshake.

Parameters:
- W, 11, I/Q sample width (two's complement), matching mapper xr/xi.
- PILOT_AMP, 1023, pilot real amplitude; imaginary part is always 0.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- valid_i  in  1  input symbol valid (mapper valid_o)
- xr_i  in  W  input real part
- xi_i  in  W  input imaginary part
- in_ready  out  1  1 = symbol accepted this cycle if valid_i
- yr_o  out  W  output real part
- yi_o  out  W  output imaginary part
- valid_o  out  1  output sample valid
- ready_i  in  1  IFFT accepts the sample
- sof_o  out  1  high with carrier 0 of each frame
- eof_o  out  1  high with carrier 63 of each frame
- frames_o  out  16  count of completed output frames; wraps at 65535 to 0

Behaviour:
- Carrier map, k = 0..63:
  - k=0 is a null (0,0).
  - k=27..37 are null guard carriers (11 carriers).
  - k=7, 21, 43, 57 are pilots (PILOT_AMP, 0).
  - All other k (48 carriers) are data, filled in ascending k from data index 0..47.
- Storage: two banks of 48 x 2W, bank_full[1:0], write bank pointer wb, read bank pointer rb, write index widx (0..47), read carrier index ridx (0..63).
- Write side:
  - in_ready = !bank_full[wb].
  - Accept on valid_i && in_ready: store at bank[wb][widx], widx+1.
  - On accepting widx==47: set bank_full[wb], widx=0, toggle wb.
- Read FSM states:
  - IDLE: if bank_full[rb], go to RUN with ridx=0.
  - RUN: present the sample for ridx on registered outputs. Advance on valid_o && ready_i. After the handshake at ridx==63: clear bank_full[rb], toggle rb, frames_o+1, return to IDLE. frames_o updates the cycle after the eof handshake.
- Latency: with the read FSM in IDLE, valid_o rises exactly 2 cycles after the cycle the 48th symbol is accepted.
- Frame spacing: back-to-back frames have 1 idle cycle (valid_o=0) between eof and the next sof.
- Stall: while valid_o && !ready_i, yr_o/yi_o/sof_o/eof_o hold stable.
- Simultaneous events:
  - Write completing a bank in the same cycle the reader frees the other bank: both updates apply; no symbol is lost.
  - Reader freeing bank X in the same cycle the writer is blocked on bank X: in_ready rises the next cycle.
- Both banks full: in_ready=0; the upstream symbol is held (not consumed).
- Width: yr_o/yi_o are passed through unmodified; nulls are exactly 0.
- Reset, including mid-frame: valid_o=0, sof_o=0, eof_o=0, yr_o=0, yi_o=0, frames_o=0, in_ready=1 (from the cycle after reset deasserts), bank_full=0, wb=rb=0, widx=ridx=0, FSM=IDLE. Partially written banks are discarded.

Optional Feature:
- Macro: PILOT_POLARITY_EN.
- Defined:
  - A 7-bit LFSR (x^7+x^4+1, seed 7'b1111111 at reset) produces one bit per frame.
  - Bit=1 negates all 4 pilots of that frame to (-PILOT_AMP, 0).
  - The LFSR advances once per completed frame (same cycle as frames_o increment); period 127 frames.
- Undefined: pilots always (+PILOT_AMP, 0); no LFSR is present.

Test Plan:
- Single frame: 48 symbols xr=d, xi=-d (d=1..48), ready_i=1 -> valid_o 2 cycles after symbol 48. k=0 and 27..37 give (0,0); k=7 gives (1023,0); k=1 gives (1,-1); k=63 gives (48,-48); sof at k=0, eof at k=63; frames_o=1.
- Back-pressure: ready_i=0 for 10 cycles at k=5 -> yr_o/yi_o/valid_o held. After release, k=5 is presented once with no skip or duplicate.
- Buffer full: 144 symbols streamed continuously with ready_i=0 -> in_ready drops after the 96th accept. Raising ready_i restarts acceptance 1 cycle after the first eof handshake, and all 3 frames emerge in order.
- Reset mid-frame: RST high at k=30 of frame 1 with 20 symbols already in the next bank -> all outputs 0, frames_o=0. A fresh 48 symbols yields a frame whose first data carrier (k=1) equals the first post-reset symbol.
- Counter wrap: force 65536 frames (or preload in sim) -> frames_o reads 0 after the 65536th eof.
- PILOT_POLARITY_EN defined: frames 1..7 have pilots -1023 (LFSR output 1s from the all-ones seed). A frame with LFSR bit 0 has +1023. Undefined: all pilots +1023.
